// File: rtl/mips_pkg.sv
// Shared writeback definitions: register/data widths, the $zero register
// index and the {addr, data} request carried by both write sources.
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous circular-buffer FIFO with push/pop/full/empty/count.
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);
  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full    = (cnt_q == (PTR_W+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_ok && !pop_ok)      cnt_d = cnt_q + (PTR_W+1)'(1);
    else if (pop_ok && !push_ok) cnt_d = cnt_q - (PTR_W+1)'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been pushed.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter: primary source has priority, secondary results drain from
// a FIFO into idle slots, plus a pending-destination scoreboard.
// Optional starvation guard enabled by defining WB_STARVE_GUARD_EN.
module reg_wb_arbiter #(
  parameter int DATA_W     = mips_pkg::DATA_W,
  parameter int ADDR_W     = mips_pkg::ADDR_W,
  parameter int FIFO_DEPTH = 4
`ifdef WB_STARVE_GUARD_EN
  , parameter int STARVE_LIMIT = 4
`endif
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        pri_wr_en,
  input  logic [ADDR_W-1:0]           pri_wr_addr,
  input  logic [DATA_W-1:0]           pri_wr_data,
  input  logic                        sec_valid,
  output logic                        sec_ready,
  input  logic [ADDR_W-1:0]           sec_wr_addr,
  input  logic [DATA_W-1:0]           sec_wr_data,
  input  logic                        iss_valid,
  input  logic [ADDR_W-1:0]           iss_dest,
  output logic [2**ADDR_W-1:0]        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt,
`ifdef WB_STARVE_GUARD_EN
  output logic                        pri_stall_req,
`endif
  output logic                        reg_write,
  output logic [ADDR_W-1:0]           rw_reg,
  output logic [DATA_W-1:0]           wr_data
);
  import mips_pkg::*;

  wb_req_t             pri_req, sec_req, head_req, sel_req;
  logic                fifo_push, fifo_pop, fifo_full, fifo_empty, sel_valid;
  logic                reg_write_q, reg_write_d;
  logic [ADDR_W-1:0]   rw_reg_q, rw_reg_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [2**ADDR_W-1:0] busy_q, busy_d;

  // Handshake: a secondary result transfers on a cycle where sec_valid and
  // sec_ready are both high; sec_ready depends only on reset and FIFO fullness.
  assign sec_ready = !i_rst && !fifo_full;
  assign fifo_push = sec_valid && sec_ready;
  assign fifo_pop  = !pri_wr_en && !fifo_empty;

  always_comb begin
    pri_req.addr = pri_wr_addr;
    pri_req.data = pri_wr_data;
    sec_req.addr = sec_wr_addr;
    sec_req.data = sec_wr_data;
  end

  wb_fifo #(
    .W     ($bits(wb_req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_sec_fifo (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (sec_req),
    .dout  (head_req),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  always_comb begin
    sel_valid   = pri_wr_en || !fifo_empty;
    sel_req     = pri_wr_en ? pri_req : head_req;
    // Writes to $zero are consumed but never reach the register file.
    reg_write_d = sel_valid && (sel_req.addr != REG_ZERO);
    rw_reg_d    = sel_valid ? sel_req.addr : rw_reg_q;
    wr_data_d   = sel_valid ? sel_req.data : wr_data_q;

    // Clear first so a same-cycle re-issue to the same register wins.
    busy_d = busy_q;
    if (fifo_pop) busy_d[head_req.addr] = 1'b0;
    if (iss_valid && iss_dest != REG_ZERO) busy_d[iss_dest] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      reg_write_q <= 1'b0;
      rw_reg_q    <= '0;
      wr_data_q   <= '0;
      busy_q      <= '0;
    end else begin
      reg_write_q <= reg_write_d;
      rw_reg_q    <= rw_reg_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
    end
  end

  assign reg_write = reg_write_q;
  assign rw_reg    = rw_reg_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;

`ifdef WB_STARVE_GUARD_EN
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  logic [SC_W-1:0] starve_cnt_q, starve_cnt_d;
  logic            stall_q, stall_d;

  // Counter saturates at the limit; the request holds until the FIFO drains one entry.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    stall_d      = stall_q;
    if (fifo_pop || fifo_empty) begin
      starve_cnt_d = '0;
      stall_d      = 1'b0;
    end else begin
      if (starve_cnt_q != SC_W'(STARVE_LIMIT)) starve_cnt_d = starve_cnt_q + SC_W'(1);
      stall_d = stall_q || (starve_cnt_d >= SC_W'(STARVE_LIMIT));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      starve_cnt_q <= '0;
      stall_q      <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      stall_q      <= stall_d;
    end
  end

  assign pri_stall_req = stall_q;
`endif
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed self-checking bench for reg_wb_arbiter; the starvation-guard
// section is built only when WB_STARVE_GUARD_EN is defined.
module tb_reg_wb_arbiter;
  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        pri_wr_en;
  logic [4:0]  pri_wr_addr;
  logic [31:0] pri_wr_data;
  logic        sec_valid;
  logic        sec_ready;
  logic [4:0]  sec_wr_addr;
  logic [31:0] sec_wr_data;
  logic        iss_valid;
  logic [4:0]  iss_dest;
  logic [31:0] busy;
  logic [2:0]  fifo_cnt;
  logic        reg_write;
  logic [4:0]  rw_reg;
  logic [31:0] wr_data;
`ifdef WB_STARVE_GUARD_EN
  logic        pri_stall_req;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Clock / reset
  always #5 i_clk = ~i_clk;

  reg_wb_arbiter dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .pri_wr_en     (pri_wr_en),
    .pri_wr_addr   (pri_wr_addr),
    .pri_wr_data   (pri_wr_data),
    .sec_valid     (sec_valid),
    .sec_ready     (sec_ready),
    .sec_wr_addr   (sec_wr_addr),
    .sec_wr_data   (sec_wr_data),
    .iss_valid     (iss_valid),
    .iss_dest      (iss_dest),
    .busy          (busy),
    .fifo_cnt      (fifo_cnt),
`ifdef WB_STARVE_GUARD_EN
    .pri_stall_req (pri_stall_req),
`endif
    .reg_write     (reg_write),
    .rw_reg        (rw_reg),
    .wr_data       (wr_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle away from it.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_pri(input logic en, input logic [4:0] a, input logic [31:0] d);
    pri_wr_en   = en;
    pri_wr_addr = a;
    pri_wr_data = d;
  endtask

  task automatic drive_sec(input logic v, input logic [4:0] a, input logic [31:0] d);
    sec_valid   = v;
    sec_wr_addr = a;
    sec_wr_data = d;
  endtask

  task automatic check_wr(input string tag, input logic [4:0] a, input logic [31:0] d);
    check({tag, "_we"},   reg_write, 1'b1);
    check({tag, "_addr"}, rw_reg, a);
    check({tag, "_data"}, wr_data, d);
  endtask

  initial begin
    i_rst = 1'b1;
    drive_pri(1'b0, 5'd0, 32'd0);
    drive_sec(1'b0, 5'd0, 32'd0);
    iss_valid = 1'b0;
    iss_dest  = 5'd0;
    tick();
    tick();

    // Reset values
    check("rst_we",    reg_write, 1'b0);
    check("rst_addr",  rw_reg, 5'd0);
    check("rst_data",  wr_data, 32'd0);
    check("rst_busy",  busy, 32'd0);
    check("rst_cnt",   fifo_cnt, 3'd0);
    check("rst_ready", sec_ready, 1'b0);
    i_rst = 1'b0;
    #1;
    check("ready_after_rst", sec_ready, 1'b1);

    // Primary write, one cycle latency, single-cycle pulse
    drive_pri(1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    check_wr("pri5", 5'd5, 32'hDEADBEEF);
    drive_pri(1'b0, 5'd0, 32'd0);
    tick();
    check("pri5_done_we", reg_write, 1'b0);
    check("pri5_hold_addr", rw_reg, 5'd5);
    check("pri5_hold_data", wr_data, 32'hDEADBEEF);

    // Secondary entries buffered while primary busy, then drained in order
    drive_pri(1'b1, 5'd1, 32'h1);
    drive_sec(1'b1, 5'd7, 32'h11);
    tick();
    check("sec_push1_cnt", fifo_cnt, 3'd1);
    check_wr("pri1_a", 5'd1, 32'h1);
    drive_sec(1'b1, 5'd8, 32'h22);
    tick();
    check("sec_push2_cnt", fifo_cnt, 3'd2);
    drive_sec(1'b0, 5'd0, 32'd0);
    drive_pri(1'b0, 5'd0, 32'd0);
    tick();
    check_wr("drain7", 5'd7, 32'h11);
    check("drain7_cnt", fifo_cnt, 3'd1);
    tick();
    check_wr("drain8", 5'd8, 32'h22);
    check("drain8_cnt", fifo_cnt, 3'd0);
    tick();
    check("drain_idle_we", reg_write, 1'b0);

    // Fill to capacity, overflow attempt ignored, ordered drain with wrap
    drive_pri(1'b1, 5'd2, 32'h2);
    for (int i = 0; i < 4; i++) begin
      drive_sec(1'b1, 5'(10 + i), 32'hA0 + 32'(i));
      tick();
    end
    check("full_cnt", fifo_cnt, 3'd4);
    check("full_ready", sec_ready, 1'b0);
    drive_sec(1'b1, 5'd14, 32'hEE);
    tick();
    check("overflow_cnt", fifo_cnt, 3'd4);
    drive_sec(1'b0, 5'd0, 32'd0);
    drive_pri(1'b0, 5'd0, 32'd0);
    tick();
    check_wr("full_drain0", 5'd10, 32'hA0);
    check("full_drain0_cnt", fifo_cnt, 3'd3);
    check("full_drain0_ready", sec_ready, 1'b1);
    tick();
    check_wr("full_drain1", 5'd11, 32'hA1);
    tick();
    check_wr("full_drain2", 5'd12, 32'hA2);
    tick();
    check_wr("full_drain3", 5'd13, 32'hA3);
    check("full_drain3_cnt", fifo_cnt, 3'd0);
    tick();
    check("full_idle_we", reg_write, 1'b0);

    // Scoreboard set, clear on pop, set wins over same-cycle clear
    iss_valid = 1'b1;
    iss_dest  = 5'd9;
    tick();
    check("busy9_set", busy, 32'h0000_0200);
    iss_valid = 1'b0;
    drive_pri(1'b1, 5'd3, 32'h3);
    drive_sec(1'b1, 5'd9, 32'h99);
    tick();
    check("busy9_held", busy, 32'h0000_0200);
    drive_pri(1'b0, 5'd0, 32'd0);
    drive_sec(1'b0, 5'd0, 32'd0);
    tick();
    check_wr("pop9", 5'd9, 32'h99);
    check("busy9_clear", busy, 32'h0);
    drive_pri(1'b1, 5'd3, 32'h3);
    drive_sec(1'b1, 5'd9, 32'h55);
    iss_valid = 1'b1;
    iss_dest  = 5'd9;
    tick();
    check("busy9_reset", busy, 32'h0000_0200);
    drive_pri(1'b0, 5'd0, 32'd0);
    drive_sec(1'b0, 5'd0, 32'd0);
    tick();
    check_wr("pop9b", 5'd9, 32'h55);
    check("busy9_set_wins", busy, 32'h0000_0200);

    // Primary write to a busy register leaves the scoreboard alone
    iss_dest = 5'd6;
    tick();
    iss_valid = 1'b0;
    check("busy6_set", busy, 32'h0000_0240);
    drive_pri(1'b1, 5'd6, 32'h66);
    tick();
    check_wr("pri6", 5'd6, 32'h66);
    check("busy6_pri_kept", busy, 32'h0000_0240);

    // Secondary to $zero popped silently; issue to $zero ignored
    drive_pri(1'b1, 5'd4, 32'h4);
    drive_sec(1'b1, 5'd0, 32'h77);
    tick();
    check("zero_push_cnt", fifo_cnt, 3'd1);
    drive_pri(1'b0, 5'd0, 32'd0);
    drive_sec(1'b0, 5'd0, 32'd0);
    iss_valid = 1'b1;
    iss_dest  = 5'd0;
    tick();
    check("zero_pop_we", reg_write, 1'b0);
    check("zero_pop_cnt", fifo_cnt, 3'd0);
    check("zero_iss_busy", busy, 32'h0000_0240);
    iss_valid = 1'b0;

    // Reset with three entries queued
    drive_pri(1'b1, 5'd2, 32'h2);
    for (int i = 0; i < 3; i++) begin
      drive_sec(1'b1, 5'(15 + i), 32'hB0 + 32'(i));
      tick();
    end
    check("prerst_cnt", fifo_cnt, 3'd3);
    drive_pri(1'b0, 5'd0, 32'd0);
    drive_sec(1'b0, 5'd0, 32'd0);
    i_rst = 1'b1;
    tick();
    check("midrst_cnt", fifo_cnt, 3'd0);
    check("midrst_busy", busy, 32'h0);
    check("midrst_we", reg_write, 1'b0);
    i_rst = 1'b0;
    tick();
    check("postrst_we1", reg_write, 1'b0);
    tick();
    check("postrst_we2", reg_write, 1'b0);
    check("postrst_cnt", fifo_cnt, 3'd0);

`ifdef WB_STARVE_GUARD_EN
    // One queued entry blocked by a continuously busy primary
    drive_pri(1'b1, 5'd1, 32'h1);
    drive_sec(1'b1, 5'd20, 32'hC0);
    tick();
    drive_sec(1'b0, 5'd0, 32'd0);
    check("guard_idle", pri_stall_req, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    check("guard_3_blocked", pri_stall_req, 1'b0);
    tick();
    check("guard_4_blocked", pri_stall_req, 1'b1);
    tick();
    tick();
    check("guard_6_blocked", pri_stall_req, 1'b1);
    drive_pri(1'b0, 5'd0, 32'd0);
    tick();
    check_wr("guard_bubble", 5'd20, 32'hC0);
    check("guard_released", pri_stall_req, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
